clk_div_sequencer: RTL and testbench
====================================

// Module: clk_div_sequencer
// PURPOSE
//   Run-time controller for the clock-divider datapath: owns the half-period counter and
//   clk_div output, starts and stops division on request, and accepts new half-period
//   values through a valid/ready handshake. New values and stop requests take effect only
//   at half-period boundaries, so clk_div never produces a runt high phase.
//   Sits between the control/register block and the logic clocked by clk_div.
// PARAMETERS
//   CNT_W         32  width of the half-period counter and the cfg_half_period port
//   DEFAULT_HALF  50  half-period in clk cycles loaded at reset (must be >= 1)
// PORTS
//   clk              in   1      system clock; all logic on the rising edge
//   rst_a            in   1      asynchronous active-low reset
//   enable           in   1      level: 1 = run divider, 0 = stop cleanly
//   cfg_valid        in   1      new half-period offered
//   cfg_half_period  in   CNT_W  requested half-period in clk cycles (0 is illegal)
//   cfg_ready        out  1      block can accept a cfg word (= no pending word)
//   cfg_err          out  1      1-cycle pulse: accepted word was 0 and was discarded
//   clk_div          out  1      divided clock, registered
//   tick             out  1      1-cycle pulse, high in the same cycle clk_div changes value
//   busy             out  1      1 in RUN or STOPPING
// BEHAVIOUR
//   Reset: one clock; reset is asynchronous and active-low (rst_a) and forces every register
//     at once: state=IDLE, count=0, half=DEFAULT_HALF, pend_valid=0, clk_div=0, tick=0,
//     cfg_err=0, busy=0, cfg_ready=1. Reset mid-operation aborts immediately; the pending
//     word is lost.
//   Boundary: in RUN or STOPPING, count==half-1. On a boundary: count<=0, clk_div<=~clk_div,
//     tick<=1. Otherwise count<=count+1 and tick<=0. half=1 toggles clk_div every cycle.
//   Handshake: a word transfers when cfg_valid && cfg_ready. cfg_ready = !pend_valid.
//     - Word 0: discarded, cfg_err=1 in the next cycle, half and pend are unchanged.
//     - State IDLE: half<=word in the next cycle, with no pending word.
//     - State RUN or STOPPING: pend<=word, pend_valid<=1. On the next boundary,
//       half<=pend and pend_valid<=0, so the new half applies from the phase that starts there.
//     - A transfer in a boundary cycle goes to pend and applies at the FOLLOWING boundary.
//     - Entering IDLE with pend_valid=1: half<=pend and pend_valid<=0 in that same transition.
//   FSM (states IDLE, RUN, STOPPING):
//     IDLE:     count=0, clk_div=0. enable=1 -> RUN. The first boundary comes half cycles
//               after entering RUN.
//     RUN:      enable=0 and clk_div=0 -> IDLE (count<=0, the low phase is cut short).
//               enable=0 and clk_div=1 -> STOPPING.
//     STOPPING: keeps counting. At the boundary, clk_div falls to 0 (tick=1) -> IDLE.
//               enable=1 before that boundary -> RUN, counting and clk_div undisturbed.
//   If enable falls in a boundary cycle, the boundary toggle happens first. The next-state
//     decision uses the post-toggle clk_div value.
//   busy is registered and equals (state!=IDLE).
//   Widths: count and half are CNT_W bits unsigned. The compare uses half-1, which never
//     wraps because half is never 0.
// TESTING
//   1 Reset, enable=1, no cfg: clk_div rises at cycle 50 and falls at cycle 100 after RUN
//     entry. tick pulses at each edge. Period = 100 clk cycles.
//   2 In IDLE, send cfg=3 then enable=1: clk_div toggles every 3 cycles. cfg_ready stays 1.
//   3 In RUN with half=4, send cfg=2 two cycles after an edge: cfg_ready=0 until the next
//     boundary. Phases after that boundary last 2 cycles. A second cfg held valid is
//     accepted the cycle after cfg_ready returns to 1.
//   4 cfg=0 in RUN: cfg_err pulses once, half is unchanged, cfg_ready stays 1.
//   5 half=5, drop enable 1 cycle into the high phase: STOPPING, clk_div falls 4 cycles
//     later, then IDLE with busy=0. Drop enable during a low phase: IDLE next cycle with no
//     clk_div edge. Re-raise enable during STOPPING: the clk_div waveform is uninterrupted.
//   6 Assert rst_a=0 mid-high-phase with a word pending: clk_div=0, busy=0, cfg_ready=1,
//     half=50 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/clk_div_sequencer_if.sv
// Purpose: configuration handshake between the control/register block and the
//          clock-divider sequencer.
// Signals:
//   cfg_valid        new half-period offered (master -> slave)
//   cfg_half_period  requested half-period in clk cycles (master -> slave)
//   cfg_ready        slave can take a word this cycle (slave -> master)
//   cfg_err          1-cycle pulse, accepted word was 0 and dropped (slave -> master)
interface clk_div_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half_period;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_half_period,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_half_period,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_sequencer.sv
// Purpose: run-time controller for the clock divider. Owns the half-period
//          counter and the registered clk_div output, starts/stops division on
//          the enable level and takes new half-periods over a valid/ready
//          handshake. Changes only land on half-period boundaries, so clk_div
//          never produces a runt high phase.
// Ports:
//   clk      system clock, rising edge
//   rst_a    asynchronous active-low reset
//   enable   level, 1 = run, 0 = stop cleanly
//   cfg      configuration handshake (slave side)
//   clk_div  divided clock, registered
//   tick     1-cycle pulse in the cycle clk_div changes
//   busy     1 while in RUN or STOPPING
//
// state    | meaning
// IDLE     | divider parked, count=0, clk_div=0
// RUN      | dividing, clk_div toggles at every boundary
// STOPPING | enable dropped during a high phase; finish it, then park
module clk_div_sequencer #(
  parameter int CNT_W        = 32,
  parameter int DEFAULT_HALF = 50
) (
  input  logic                clk,
  input  logic                rst_a,
  input  logic                enable,
  clk_div_sequencer_if.slave  cfg,
  output logic                clk_div,
  output logic                tick,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic             busy_q, busy_d;

  logic             running;
  logic             boundary;
  logic             xfer;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q      <= IDLE;
      count_q      <= '0;
      half_q       <= CNT_W'(DEFAULT_HALF);
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      clk_div_q    <= 1'b0;
      tick_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      half_q       <= half_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      clk_div_q    <= clk_div_d;
      tick_q       <= tick_d;
      cfg_err_q    <= cfg_err_d;
      busy_q       <= busy_d;
    end
  end

  // half is never 0, so half_q - 1 cannot wrap.
  assign running  = (state_q != IDLE);
  assign boundary = running && (count_q == (half_q - CNT_W'(1)));
  assign xfer     = cfg.cfg_valid && !pend_valid_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    half_d       = half_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    clk_div_d    = clk_div_q;
    tick_d       = 1'b0;
    cfg_err_d    = 1'b0;

    // Counter / toggle datapath
    if (running) begin
      if (boundary) begin
        count_d   = '0;
        clk_div_d = ~clk_div_q;
        tick_d    = 1'b1;
        if (pend_valid_q) begin
          half_d       = pend_q;
          pend_valid_d = 1'b0;
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    // A transfer can only happen with no pending word, so it never collides
    // with the boundary hand-over above; a word taken in a boundary cycle
    // waits for the following boundary.
    if (xfer) begin
      if (cfg.cfg_half_period == '0) begin
        cfg_err_d = 1'b1;
      end else if (state_q == IDLE) begin
        half_d = cfg.cfg_half_period;
      end else begin
        pend_d       = cfg.cfg_half_period;
        pend_valid_d = 1'b1;
      end
    end

    // Next-state decisions look at the post-toggle clk_div value.
    case (state_q)
      IDLE: begin
        count_d   = '0;
        clk_div_d = 1'b0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          if (clk_div_d) begin
            state_d = STOPPING;
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
        end
      end
      STOPPING: begin
        // enable wins over the closing boundary so the waveform keeps going.
        if (enable) begin
          state_d = RUN;
        end else if (boundary) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        count_d   = '0;
        clk_div_d = 1'b0;
      end
    endcase

    // A word still waiting when we park becomes the new half right away.
    if (state_d == IDLE && state_q != IDLE && pend_valid_d) begin
      half_d       = pend_d;
      pend_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign cfg.cfg_ready = ~pend_valid_q;
  assign cfg.cfg_err   = cfg_err_q;
  assign clk_div       = clk_div_q;
  assign tick          = tick_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed bench for clk_div_sequencer. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_clk_div_sequencer;

  localparam int CNT_W = 32;

  logic clk;
  logic rst_a;
  logic enable;
  logic clk_div;
  logic tick;
  logic busy;

  int   chk_cnt;
  int   err_cnt;
  int   n;

  clk_div_sequencer_if #(.CNT_W(CNT_W)) cfg_if ();

  clk_div_sequencer #(.CNT_W(CNT_W), .DEFAULT_HALF(50)) dut (
    .clk     (clk),
    .rst_a   (rst_a),
    .enable  (enable),
    .cfg     (cfg_if.slave),
    .clk_div (clk_div),
    .tick    (tick),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Counts falling edges until tick is seen, bounded by limit.
  task automatic wait_tick(input string tag, input int limit, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!tick && cnt < limit);
    if (!tick) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic send_idle_cfg(input logic [31:0] word);
    cfg_if.cfg_valid       = 1'b1;
    cfg_if.cfg_half_period = word;
    cyc();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic stop_run();
    int k;
    enable = 1'b0;
    k = 0;
    do begin
      cyc();
      k++;
    end while (busy && k < 300);
    chk("stop_idle", busy, 0);
  endtask

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    rst_a   = 1'b0;
    enable  = 1'b0;
    cfg_if.cfg_valid       = 1'b0;
    cfg_if.cfg_half_period = '0;
    repeat (2) cyc();

    // reset state
    chk("rst_clk_div", clk_div, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    chk("rst_err", cfg_if.cfg_err, 0);
    rst_a = 1'b1;
    cyc();

    // 1: default half = 50
    enable = 1'b1;
    wait_tick("t1_first", 200, n);
    chk("t1_first_len", n, 51);
    chk("t1_rise", clk_div, 1);
    chk("t1_busy", busy, 1);
    wait_tick("t1_second", 200, n);
    chk("t1_high_len", n, 50);
    chk("t1_fall", clk_div, 0);
    wait_tick("t1_third", 200, n);
    chk("t1_low_len", n, 50);
    wait_tick("t1_fourth", 200, n);
    chk("t1_fall2", clk_div, 0);
    stop_run();

    // 2: cfg=3 in IDLE
    cfg_if.cfg_valid       = 1'b1;
    cfg_if.cfg_half_period = 32'd3;
    chk("t2_ready_pre", cfg_if.cfg_ready, 1);
    cyc();
    cfg_if.cfg_valid = 1'b0;
    chk("t2_ready_post", cfg_if.cfg_ready, 1);
    enable = 1'b1;
    wait_tick("t2_first", 50, n);
    chk("t2_first_len", n, 4);
    wait_tick("t2_p1", 50, n);
    chk("t2_p1_len", n, 3);
    wait_tick("t2_p2", 50, n);
    chk("t2_p2_len", n, 3);
    stop_run();

    // 3: half=4 running, cfg=2 mid-phase, second word held valid
    send_idle_cfg(32'd4);
    enable = 1'b1;
    wait_tick("t3_first", 50, n);
    chk("t3_first_len", n, 5);
    repeat (2) cyc();
    cfg_if.cfg_valid       = 1'b1;
    cfg_if.cfg_half_period = 32'd2;
    cyc();
    cfg_if.cfg_half_period = 32'd3;
    chk("t3_ready_pend", cfg_if.cfg_ready, 0);
    cyc();
    chk("t3_boundary_tick", tick, 1);
    chk("t3_ready_back", cfg_if.cfg_ready, 1);
    cyc();
    chk("t3_second_taken", cfg_if.cfg_ready, 0);
    cfg_if.cfg_valid = 1'b0;
    wait_tick("t3_half2", 50, n);
    chk("t3_half2_len", n, 1);
    wait_tick("t3_half3a", 50, n);
    chk("t3_half3a_len", n, 3);
    wait_tick("t3_half3b", 50, n);
    chk("t3_half3b_len", n, 3);

    // 4: cfg=0 while running (half=3)
    cfg_if.cfg_valid       = 1'b1;
    cfg_if.cfg_half_period = 32'd0;
    cyc();
    cfg_if.cfg_valid = 1'b0;
    chk("t4_err", cfg_if.cfg_err, 1);
    chk("t4_ready", cfg_if.cfg_ready, 1);
    cyc();
    chk("t4_err_once", cfg_if.cfg_err, 0);
    wait_tick("t4_rest", 50, n);
    chk("t4_rest_len", n, 1);
    wait_tick("t4_full", 50, n);
    chk("t4_full_len", n, 3);
    stop_run();

    // 5a: half=5, drop enable 1 cycle into the high phase
    send_idle_cfg(32'd5);
    enable = 1'b1;
    wait_tick("t5_rise", 50, n);
    chk("t5_rise_len", n, 6);
    chk("t5_rise_val", clk_div, 1);
    cyc();
    enable = 1'b0;
    wait_tick("t5_stop_fall", 50, n);
    chk("t5_stop_fall_len", n, 4);
    chk("t5_stop_clk", clk_div, 0);
    chk("t5_stop_busy", busy, 0);

    // 5b: drop enable during a low phase
    enable = 1'b1;
    wait_tick("t5b_rise", 50, n);
    wait_tick("t5b_fall", 50, n);
    chk("t5b_high_len", n, 5);
    cyc();
    enable = 1'b0;
    cyc();
    chk("t5b_busy", busy, 0);
    chk("t5b_tick", tick, 0);
    chk("t5b_clk", clk_div, 0);

    // 5c: re-raise enable during STOPPING
    enable = 1'b1;
    wait_tick("t5c_rise", 50, n);
    chk("t5c_rise_len", n, 6);
    enable = 1'b0;
    cyc();
    chk("t5c_stopping_busy", busy, 1);
    enable = 1'b1;
    cyc();
    wait_tick("t5c_fall", 50, n);
    chk("t5c_fall_len", n, 3);
    chk("t5c_fall_val", clk_div, 0);
    wait_tick("t5c_low", 50, n);
    chk("t5c_low_len", n, 5);
    chk("t5c_busy", busy, 1);

    // 6: async reset in the high phase with a word pending
    cyc();
    cfg_if.cfg_valid       = 1'b1;
    cfg_if.cfg_half_period = 32'd7;
    cyc();
    cfg_if.cfg_valid = 1'b0;
    chk("t6_pending", cfg_if.cfg_ready, 0);
    chk("t6_high", clk_div, 1);
    #2;
    rst_a = 1'b0;
    #1;
    chk("t6_rst_clk", clk_div, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", cfg_if.cfg_ready, 1);
    chk("t6_rst_tick", tick, 0);
    enable = 1'b0;
    cyc();
    rst_a = 1'b1;
    enable = 1'b1;
    wait_tick("t6_default", 200, n);
    chk("t6_default_len", n, 51);
    stop_run();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
